// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised, mid-bit sampled; valid pulses t0+HALF+K*DIV+1 (t0 = START entry, 3 cycles after the pin edge).
// No backpressure: each completed frame produces one valid pulse, and the data output holds until the next pulse.
module uart_rx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_err,
  output logic                         o_user_rx_busy
);

  localparam int W    = P_UART_DATA_WIDTH;
  localparam int DIV  = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [3:0]    DATA_LAST = 4'(W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          stb;
  logic          tick;
  logic          start_det;
  logic [3:0]    bit_cnt;
  logic [W-1:0]  shreg;
  logic          par_err;
  logic          frm_err;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_comb begin
    start_det = (state == S_IDLE) && rx_d && !rx_s2;
    term      = (state == S_START) ? HALF_M1 : DIV_M1;
    tick      = (state != S_IDLE) && (cnt == term) && !stb;
  end

  // stb is the registered terminal count, so each sample lands one cycle after the counter wraps
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
      stb <= 1'b0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
      stb <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      stb <= 1'b1;
    end else begin
      cnt <= (cnt == DIV_M1) ? '0 : cnt + 1'b1;
      stb <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= S_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      par_err         <= 1'b0;
      frm_err         <= 1'b0;
      o_user_rx_data  <= '0;
      o_user_rx_valid <= 1'b0;
      o_user_rx_err   <= 1'b0;
    end else begin
      o_user_rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
          if (start_det) state <= S_START;
        end
        S_START: begin
          if (stb) state <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (stb) begin
            shreg <= {rx_s2, shreg[W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (stb) begin
            par_err <= (P_UART_CHECK == 1) ? ~(^shreg ^ rx_s2) : (^shreg ^ rx_s2);
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (stb) begin
            if (!rx_s2) frm_err <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              state           <= S_IDLE;
              o_user_rx_valid <= 1'b1;
              o_user_rx_data  <= shreg;
              o_user_rx_err   <= par_err | frm_err | ~rx_s2;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb o_user_rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no parity/1 stop, even/1 stop, odd/2 stop) at DIV=10,
// driven with directed and random frames; a per-instance queue of expected frames is checked on each valid pulse.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [7:0] dat0, dat1, dat2;
  logic [2:0] vld, err, busy;
  logic [2:0] pb = 3'b000;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_uart_rx(rx_line[0]), .o_user_rx_data(dat0),
    .o_user_rx_valid(vld[0]), .o_user_rx_err(err[0]), .o_user_rx_busy(busy[0]));

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_uart_rx(rx_line[1]), .o_user_rx_data(dat1),
    .o_user_rx_valid(vld[1]), .o_user_rx_err(err[1]), .o_user_rx_busy(busy[1]));

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(1)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_uart_rx(rx_line[2]), .o_user_rx_data(dat2),
    .o_user_rx_valid(vld[2]), .o_user_rx_err(err[2]), .o_user_rx_busy(busy[2]));

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int stop_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_out(input int d, input logic v, input logic [7:0] dat,
                           input logic e_out, input logic b, input logic pbusy);
    exp_t e;
    if (!v) return;
    if (qsize(d) == 0) begin
      chk($sformatf("dut%0d_unexpected_valid", d), 1, 0);
      return;
    end
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("dut%0d_data", d), int'(dat), int'(e.data));
    chk($sformatf("dut%0d_err", d), int'(e_out), int'(e.err));
    chk($sformatf("dut%0d_valid_cycle", d), cyc, e.cyc);
    chk($sformatf("dut%0d_busy_in_valid", d), int'(b), 0);
    chk($sformatf("dut%0d_busy_before_valid", d), int'(pbusy), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_out(0, vld[0], dat0, err[0], busy[0], pb[0]);
      check_out(1, vld[1], dat1, err[1], busy[1], pb[1]);
      check_out(2, vld[2], dat2, err[2], busy[2], pb[2]);
    end
    pb = busy;
  end

  // Each call starts just after a rising edge and returns just after one.
  task automatic drive(input int d, input logic v, input int n);
    rx_line[d] = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic p, input logic [1:0] stops);
    exp_t e;
    int   m, sw, k, c;
    logic perr, serr;
    m    = mode_of(d);
    sw   = stop_of(d);
    c    = cyc;
    perr = (m != 0) && ((($countones(data) + int'(p)) % 2) != ((m == 1) ? 1 : 0));
    serr = (stops[0] == 1'b0) || (sw == 2 && stops[1] == 1'b0);
    k    = 8 + ((m != 0) ? 1 : 0) + sw;
    e.data = data;
    e.err  = perr | serr;
    e.cyc  = c + 3 + HALF + k * DIV + 1;
    push(d, e);
    drive(d, 1'b0, DIV);
    for (int i = 0; i < 8; i++) drive(d, data[i], DIV);
    if (m != 0) drive(d, p, DIV);
    for (int i = 0; i < sw; i++) drive(d, stops[i], DIV);
  endtask

  function automatic logic good_par(input int d, input logic [7:0] data);
    return (mode_of(d) == 2) ? ($countones(data) % 2 == 1) : ($countones(data) % 2 == 0);
  endfunction

  initial begin
    exp_t brk;
    int   c, gap, sw;
    logic [7:0] data;
    logic [1:0] stops;
    logic p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data0", int'(dat0), 0);
    chk("reset_data2", int'(dat2), 0);
    chk("reset_valid", int'(vld), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 5);

    // back-to-back frames
    send(0, 8'h55, 1'b0, 2'b11);
    send(0, 8'hA3, 1'b0, 2'b11);
    drive(0, 1'b1, 10);

    // three-cycle glitch
    c = cyc;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 1);
    chk("glitch_busy_high", int'(busy[0]), 1);
    drive(0, 1'b1, 15);
    chk("glitch_busy_low", int'(busy[0]), 0);
    chk("glitch_elapsed", cyc - c, 19);

    // framing error then a good frame
    send(0, 8'h3C, 1'b0, 2'b10);
    drive(0, 1'b1, 20);
    send(0, 8'h01, 1'b0, 2'b11);
    drive(0, 1'b1, 10);

    // even and odd parity instances
    send(1, 8'h07, 1'b1, 2'b11);
    send(1, 8'h07, 1'b0, 2'b11);
    drive(1, 1'b1, 10);
    send(2, 8'h00, 1'b1, 2'b11);
    send(2, 8'h00, 1'b1, 2'b01);
    drive(2, 1'b1, 20);

    // line held low: exactly one all-zero frame with error
    brk.data = 8'h00;
    brk.err  = 1'b1;
    brk.cyc  = cyc + 3 + HALF + 9 * DIV + 1;
    push(0, brk);
    drive(0, 1'b0, 250);
    drive(0, 1'b1, 30);

    // reset in the middle of a data bit
    drive(0, 1'b0, DIV);
    drive(0, 1'b1, DIV);
    drive(0, 1'b1, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy[0]), 0);
    chk("midreset_valid", int'(vld[0]), 0);
    chk("midreset_data", int'(dat0), 0);
    rx_line = 3'b111;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 3);
    rst_n = 1'b1;
    drive(0, 1'b1, 20);
    send(0, 8'h12, 1'b0, 2'b11);
    drive(0, 1'b1, 20);

    // random frames with occasional parity and stop-bit corruption
    for (int d = 0; d < 3; d++) begin
      sw = stop_of(d);
      for (int n = 0; n < 20; n++) begin
        data  = 8'($urandom);
        p     = good_par(d, data) ^ ($urandom_range(0, 3) == 0);
        stops = 2'b11;
        if ($urandom_range(0, 5) == 0) stops[0] = 1'b0;
        if ($urandom_range(0, 5) == 0) stops[1] = 1'b0;
        send(d, data, p, stops);
        gap = $urandom_range(0, 15);
        if (stops[sw-1] == 1'b0) gap += DIV;
        drive(d, 1'b1, gap);
      end
      drive(d, 1'b1, 20);
    end

    for (int i = 0; i < 3000 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    chk("pending_dut0", q0.size(), 0);
    chk("pending_dut1", q1.size(), 0);
    chk("pending_dut2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side partner of the UART transmitter. It oversamples the asynchronous serial line `i_uart_rx` on the system clock and recovers each frame: start bit, data LSB first, optional parity, then stop bit(s). It delivers each received word to user logic as a single-cycle valid pulse, with an error flag. It sits between the board RX pin and the user receive interface.

## Interface
- P_SYSTEM_CLK, 50_000_000, system clock frequency in Hz
- P_UART_BUADRATE, 9600, line baud rate
- P_UART_DATA_WIDTH, 8, data bits per frame (5..8)
- P_UART_STOP_WIDTH, 1, stop bits per frame (1 or 2)
- P_UART_CHECK, 0, parity mode: 0 none, 1 odd, 2 even
- i_clk  in  1  system clock; all logic on the rising edge
- i_rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_uart_rx  in  1  serial line, asynchronous to i_clk, idle high
- o_user_rx_data  out  P_UART_DATA_WIDTH  last received word, LSB = first data bit on the line
- o_user_rx_valid  out  1  one-cycle pulse when a frame completes
- o_user_rx_err  out  1  parity or framing error for the frame; meaningful only while o_user_rx_valid=1
- o_user_rx_busy  out  1  high while a frame is being received (any state except IDLE)

## Operation
- Bit period: DIV = P_SYSTEM_CLK / P_UART_BUADRATE, truncated (5208 at defaults). Half period: HALF = DIV/2, truncated.
- Synchronizer: i_uart_rx passes through 2 flops (rx_s1, rx_s2). Both reset to 1.
- Start detect: a third flop rx_d holds the previous rx_s2. Start is detected in IDLE when rx_d=1 and rx_s2=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on start detect. The baud counter clears to 0.
  - START: the counter counts to HALF-1, then rx_s2 is sampled.
    - Sample 0: go to DATA, counter clears.
    - Sample 1: glitch. Go to IDLE with no output.
  - DATA: sample every DIV cycles, when the counter reaches DIV-1. Samples shift in LSB first.
    - After P_UART_DATA_WIDTH samples: go to PARITY if P_UART_CHECK != 0, otherwise go to STOP.
  - PARITY: one sample taken.
    - Odd mode: error if XOR(data, sample) != 1.
    - Even mode: error if XOR(data, sample) != 0.
  - STOP: P_UART_STOP_WIDTH samples taken. Framing error if any stop sample is 0.
    - After the last stop sample, go to IDLE.
    - On the next cycle: o_user_rx_valid=1 and o_user_rx_data updated.
    - o_user_rx_err = parity error OR framing error.
- Data is delivered even when err=1.
- No backpressure. o_user_rx_data holds its value until the next valid pulse.
- The counter width is clog2(DIV). The counter is never allowed to exceed DIV-1.
- A new start edge is accepted on the first IDLE cycle. A frame may therefore begin during the second half of the previous stop bit.

## Timing
- Reset values:
  - o_user_rx_data = 0
  - o_user_rx_valid = 0
  - o_user_rx_err = 0
  - o_user_rx_busy = 0
  - FSM in IDLE
  - sync flops = 1
- Define t0 as the cycle in which the FSM enters START.
  - The start bit is sampled at t0+HALF.
  - Bit k, where k counts from 1 through data, parity and stop bits in order, is sampled at t0+HALF+k*DIV.
- Define K = P_UART_DATA_WIDTH + (P_UART_CHECK != 0) + P_UART_STOP_WIDTH.
  - o_user_rx_valid is high for exactly the single cycle t0+HALF+K*DIV+1.
- Pin-to-t0 latency is 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- o_user_rx_busy is high from t0 through the cycle in which the last stop bit is sampled. It is low in the valid cycle.
- Asynchronous reset mid-frame returns the block to IDLE immediately with all outputs at their reset values. No partial-frame valid is produced.
- If the line is held low (break), one frame completes with err=1 and data=0. The next frame is not started until a 1->0 edge occurs on the line.

## Test plan
- Use P_SYSTEM_CLK=1_000_000 and P_UART_BUADRATE=100_000, giving DIV=10 and HALF=5.
- Default parity and stop settings; send 0x55 then 0xA3 back-to-back (stop bit 1) -> two valid pulses: data 0x55 err 0, then data 0xA3 err 0. Each pulse occurs exactly at t0+5+9*10+1.
- Drive i_uart_rx low for 3 cycles while idle -> no valid; busy high then low; FSM back in IDLE.
- Send 0x3C with stop bit forced to 0 -> valid with data 0x3C, err 1. A following good frame 0x01 -> err 0.
- P_UART_CHECK=2 (even): send 0x07 with parity bit 1 -> err 0. Send 0x07 with parity bit 0 -> err 1.
- P_UART_CHECK=1 (odd) with P_UART_STOP_WIDTH=2: send 0x00 with parity 1 and two stop bits -> err 0. Repeat with the second stop bit at 0 -> err 1.
- Assert i_rst mid-data-bit of 0xFF, release, then send 0x12 -> no valid for the interrupted frame; one valid with data 0x12, err 0.
